pwm_duty_sched: RTL and testbench

//  Duty-cycle scheduler for the serialized PWM outputs. Accepts duty updates from up to NREQ

---
 rtl/pwm_pkg.sv | 30 +++
 rtl/pwm_duty_sched_rr_arb.sv | 48 ++++
 rtl/pwm_duty_sched.sv | 116 +++++++++++
 tb/tb_pwm_duty_sched.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared parameters, types and duty helpers for the PWM duty scheduler
package pwm_pkg;

    localparam int NCH      = 2;
    localparam int NREQ     = 2;
    localparam int DUTY_W   = 12;
    localparam int PERIOD   = 2047;
    localparam int DUTY_RST = 0;
    localparam int MAX_STEP = 16;
    localparam int CH_W     = (NCH > 1) ? $clog2(NCH) : 1;

    typedef logic [DUTY_W-1:0] duty_t;
    typedef logic [CH_W-1:0]   ch_t;

    function automatic duty_t clamp_duty(input duty_t d);
        return (d > duty_t'(PERIOD)) ? duty_t'(PERIOD) : d;
    endfunction

    // One slew step of active toward target, computed in DUTY_W+1 signed.
    function automatic duty_t slew_step(input duty_t act, input duty_t tgt);
        logic signed [DUTY_W:0] diff;
        logic signed [DUTY_W:0] lim;
        diff = $signed({1'b0, tgt}) - $signed({1'b0, act});
        lim  = (DUTY_W+1)'(MAX_STEP);
        if (diff > lim)  return act + duty_t'(MAX_STEP);
        if (diff < -lim) return act - duty_t'(MAX_STEP);
        return tgt;
    endfunction

endpackage

// File: rtl/pwm_duty_sched_rr_arb.sv
// rtl/pwm_duty_sched_rr_arb.sv - round-robin arbiter, one-hot grant searched from a rotating pointer
module rr_arb #(
    parameter int N = 2
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [N-1:0] valid_i,
    output logic [N-1:0] grant_o
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;
    logic [PW-1:0] idx;
    logic [PW-1:0] win;
    logic          found;

    always_comb begin
        idx   = '0;
        win   = ptr_q;
        found = 1'b0;
        for (int off = 0; off < N; off++) begin
            idx = PW'((int'(ptr_q) + off) % N);
            if (!found && valid_i[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    // Grant equals accept: the requester transfers whenever it is granted.
    always_comb begin
        grant_o = '0;
        if (found && !rst_i) grant_o[win] = 1'b1;
    end

    always_comb begin
        ptr_d = ptr_q;
        if (found) ptr_d = (win == PW'(N - 1)) ? '0 : win + PW'(1);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) ptr_q <= '0;
        else       ptr_q <= ptr_d;
    end

endmodule

// File: rtl/pwm_duty_sched.sv
// rtl/pwm_duty_sched.sv - shadow/active duty registers committed at PWM period boundaries
// Build option: SLEW_LIMIT_EN limits each commit to MAX_STEP toward the shadow value.
module pwm_duty_sched
    import pwm_pkg::*;
(
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [NREQ-1:0]        req_valid_i,
    output logic [NREQ-1:0]        req_ready_o,
    input  logic [NREQ*CH_W-1:0]   req_ch_i,
    input  logic [NREQ*DUTY_W-1:0] req_duty_i,
    input  logic                   period_end_i,
    output logic [NCH*DUTY_W-1:0]  duty_out_o,
    output logic                   duty_load_o,
    output logic [NCH-1:0]         pending_o,
    output logic [NCH-1:0]         ovw_flag_o,
    output logic                   bad_ch_o,
    input  logic                   clr_flags_i
);

    duty_t          shadow_q [NCH];
    duty_t          shadow_d [NCH];
    duty_t          active_q [NCH];
    duty_t          active_d [NCH];
    logic [NCH-1:0] pending_q, pending_d;
    logic [NCH-1:0] ovw_q, ovw_d;
    logic           bad_q, bad_d;
    logic           load_q, load_d;

    logic [NREQ-1:0] grant;
    logic            accept;
    ch_t             sel_ch;
    duty_t           sel_duty;
    logic            ch_ok;

    rr_arb #(.N(NREQ)) u_arb (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .valid_i (req_valid_i),
        .grant_o (grant)
    );

    assign req_ready_o = grant;
    assign accept      = |grant;
    assign ch_ok       = int'(sel_ch) < NCH;

    always_comb begin
        sel_ch   = '0;
        sel_duty = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                sel_ch   = req_ch_i[i*CH_W +: CH_W];
                sel_duty = req_duty_i[i*DUTY_W +: DUTY_W];
            end
        end
    end

    // Commit reads the registered shadow, so an accept in the same cycle lands for the next period.
    always_comb begin
        shadow_d  = shadow_q;
        active_d  = active_q;
        pending_d = pending_q;
        load_d    = 1'b0;
        ovw_d     = clr_flags_i ? '0 : ovw_q;
        bad_d     = clr_flags_i ? 1'b0 : bad_q;
        for (int c = 0; c < NCH; c++) begin
            if (period_end_i && pending_q[c]) begin
`ifdef SLEW_LIMIT_EN
                active_d[c]  = slew_step(active_q[c], shadow_q[c]);
                pending_d[c] = (active_d[c] != shadow_q[c]);
`else
                active_d[c]  = shadow_q[c];
                pending_d[c] = 1'b0;
`endif
                if (active_d[c] != active_q[c]) load_d = 1'b1;
            end
            if (accept && ch_ok && sel_ch == ch_t'(c)) begin
                shadow_d[c]  = clamp_duty(sel_duty);
                pending_d[c] = 1'b1;
                if (pending_q[c]) ovw_d[c] = 1'b1;
            end
        end
        if (accept && !ch_ok) bad_d = 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int c = 0; c < NCH; c++) begin
                shadow_q[c] <= duty_t'(DUTY_RST);
                active_q[c] <= duty_t'(DUTY_RST);
            end
            pending_q <= '0;
            ovw_q     <= '0;
            bad_q     <= 1'b0;
            load_q    <= 1'b0;
        end else begin
            shadow_q  <= shadow_d;
            active_q  <= active_d;
            pending_q <= pending_d;
            ovw_q     <= ovw_d;
            bad_q     <= bad_d;
            load_q    <= load_d;
        end
    end

    always_comb begin
        duty_out_o = '0;
        for (int c = 0; c < NCH; c++) duty_out_o[c*DUTY_W +: DUTY_W] = active_q[c];
    end

    assign duty_load_o = load_q;
    assign pending_o   = pending_q;
    assign ovw_flag_o  = ovw_q;
    assign bad_ch_o    = bad_q;

endmodule

// File: tb/tb_pwm_duty_sched.sv
// tb/tb_pwm_duty_sched.sv - directed self-checking bench for pwm_duty_sched
module tb_pwm_duty_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [1:0]  req_ch;
    logic [23:0] req_duty;
    logic        period_end;
    logic [23:0] duty_out;
    logic        duty_load;
    logic [1:0]  pending;
    logic [1:0]  ovw_flag;
    logic        bad_ch;
    logic        clr_flags;

    int errs   = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pwm_duty_sched dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_ch_i     (req_ch),
        .req_duty_i   (req_duty),
        .period_end_i (period_end),
        .duty_out_o   (duty_out),
        .duty_load_o  (duty_load),
        .pending_o    (pending),
        .ovw_flag_o   (ovw_flag),
        .bad_ch_o     (bad_ch),
        .clr_flags_i  (clr_flags)
    );

    function automatic logic [11:0] d_of(input int c);
        return duty_out[c*12 +: 12];
    endfunction

    task cyc();
        @(posedge clk);
        #1;
    endtask

    task settle();
        #3;
    endtask

    task wr(input int r, input logic ch, input logic [11:0] d);
        req_valid    = '0;
        req_valid[r] = 1'b1;
        req_ch[r]    = ch;
        req_duty[r*12 +: 12] = d;
        cyc();
        req_valid = '0;
    endtask

    task pulse_pe();
        period_end = 1'b1;
        cyc();
        period_end = 1'b0;
    endtask

    task test_reset();
        rst = 1'b1; req_valid = 2'b11; req_ch = 2'b10; req_duty = {12'h111, 12'h222};
        period_end = 1'b0; clr_flags = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cyc(); settle();
            checks++;
            if (req_ready !== 2'b00) begin errs++; $display("FAIL reset_ready: got %b expected 00", req_ready); end
        end
        checks++;
        if (duty_out !== 24'h0) begin errs++; $display("FAIL reset_duty: got %h expected 000000", duty_out); end
        checks++;
        if (pending !== 2'b00) begin errs++; $display("FAIL reset_pending: got %b expected 00", pending); end
        checks++;
        if (duty_load !== 1'b0) begin errs++; $display("FAIL reset_load: got %b expected 0", duty_load); end
        checks++;
        if ({ovw_flag, bad_ch} !== 3'b000) begin errs++; $display("FAIL reset_flags: got %b expected 000", {ovw_flag, bad_ch}); end
        rst = 1'b0; req_valid = '0;
    endtask

    task test_commit();
        req_valid = 2'b01; req_ch[0] = 1'b1; req_duty[11:0] = 12'h200;
        settle();
        checks++;
        if (req_ready !== 2'b01) begin errs++; $display("FAIL commit_ready: got %b expected 01", req_ready); end
        cyc(); req_valid = '0;
        checks++;
        if (pending !== 2'b10) begin errs++; $display("FAIL commit_pend_set: got %b expected 10", pending); end
        checks++;
        if (d_of(1) !== 12'h000) begin errs++; $display("FAIL commit_early: got %h expected 000", d_of(1)); end
        pulse_pe();
        checks++;
        if (d_of(1) !== 12'h200) begin errs++; $display("FAIL commit_duty: got %h expected 200", d_of(1)); end
        checks++;
        if (duty_load !== 1'b1) begin errs++; $display("FAIL commit_load: got %b expected 1", duty_load); end
        checks++;
        if (pending !== 2'b00) begin errs++; $display("FAIL commit_pend_clr: got %b expected 00", pending); end
        pulse_pe();
        checks++;
        if (duty_load !== 1'b0) begin errs++; $display("FAIL idle_pe_load: got %b expected 0", duty_load); end
        wr(0, 1'b1, 12'h900);
        pulse_pe();
        checks++;
        if (d_of(1) !== 12'h7FF) begin errs++; $display("FAIL clamp: got %h expected 7ff", d_of(1)); end
        wr(0, 1'b1, 12'h7FF);
        pulse_pe();
        checks++;
        if ({pending, duty_load} !== 3'b000) begin errs++; $display("FAIL same_value: got %b expected 000", {pending, duty_load}); end
    endtask

    task test_arbitration();
        rst = 1'b1; cyc(); rst = 1'b0;
        req_valid = 2'b11; req_ch = 2'b10; req_duty = {12'h020, 12'h010};
        settle();
        checks++;
        if (req_ready !== 2'b01) begin errs++; $display("FAIL arb_first: got %b expected 01", req_ready); end
        cyc(); settle();
        checks++;
        if (req_ready !== 2'b10) begin errs++; $display("FAIL arb_second: got %b expected 10", req_ready); end
        cyc(); settle();
        checks++;
        if (req_ready !== 2'b01) begin errs++; $display("FAIL arb_third: got %b expected 01", req_ready); end
        cyc(); req_valid = '0;
        checks++;
        if (pending !== 2'b11) begin errs++; $display("FAIL arb_pending: got %b expected 11", pending); end
        checks++;
        if (ovw_flag !== 2'b01) begin errs++; $display("FAIL arb_ovw: got %b expected 01", ovw_flag); end
`ifndef SLEW_LIMIT_EN
        pulse_pe();
        checks++;
        if (duty_out !== {12'h020, 12'h010}) begin errs++; $display("FAIL arb_duty: got %h expected 020010", duty_out); end
`endif
        clr_flags = 1'b1; cyc(); clr_flags = 1'b0;
        checks++;
        if (ovw_flag !== 2'b00) begin errs++; $display("FAIL arb_clr: got %b expected 00", ovw_flag); end
    endtask

    task test_overwrite();
        wr(1, 1'b0, 12'h100);
        checks++;
        if ({ovw_flag, pending} !== 4'b0001) begin errs++; $display("FAIL ovw_first: got %b expected 0001", {ovw_flag, pending}); end
        wr(1, 1'b0, 12'h180);
        checks++;
        if (ovw_flag !== 2'b01) begin errs++; $display("FAIL ovw_set: got %b expected 01", ovw_flag); end
        pulse_pe();
        checks++;
        if (d_of(0) !== 12'h180) begin errs++; $display("FAIL ovw_last_wins: got %h expected 180", d_of(0)); end
        clr_flags = 1'b1; cyc(); clr_flags = 1'b0;
        checks++;
        if (ovw_flag !== 2'b00) begin errs++; $display("FAIL ovw_clr: got %b expected 00", ovw_flag); end
        wr(0, 1'b0, 12'h1A0);
        clr_flags = 1'b1;
        wr(0, 1'b0, 12'h1C0);
        clr_flags = 1'b0;
        checks++;
        if (ovw_flag !== 2'b01) begin errs++; $display("FAIL ovw_set_wins: got %b expected 01", ovw_flag); end
        clr_flags = 1'b1; cyc(); clr_flags = 1'b0;
        pulse_pe();
        checks++;
        if ({ovw_flag, d_of(0)} !== {2'b00, 12'h1C0}) begin errs++; $display("FAIL ovw_final: got %h expected 01c0", {ovw_flag, d_of(0)}); end
    endtask

    task test_coincident();
        wr(0, 1'b0, 12'h250);
        req_valid = 2'b01; req_ch[0] = 1'b0; req_duty[11:0] = 12'h300; period_end = 1'b1;
        cyc();
        req_valid = '0; period_end = 1'b0;
        checks++;
        if (d_of(0) !== 12'h250) begin errs++; $display("FAIL coin_old: got %h expected 250", d_of(0)); end
        checks++;
        if ({pending[0], duty_load} !== 2'b11) begin errs++; $display("FAIL coin_pend_load: got %b expected 11", {pending[0], duty_load}); end
        pulse_pe();
        checks++;
        if ({pending[0], d_of(0)} !== {1'b0, 12'h300}) begin errs++; $display("FAIL coin_next: got %h expected 0300", {pending[0], d_of(0)}); end
    endtask

    task test_slew();
        rst = 1'b1; cyc(); rst = 1'b0;
        wr(0, 1'b0, 12'd100);
`ifdef SLEW_LIMIT_EN
        begin
            int exp_s [7] = '{16, 32, 48, 64, 80, 96, 100};
            for (int k = 0; k < 7; k++) begin
                pulse_pe();
                checks++;
                if (d_of(0) !== 12'(exp_s[k]) || duty_load !== 1'b1 || pending[0] !== (k < 6))
                begin
                    errs++;
                    $display("FAIL slew_step%0d: got duty=%0d load=%b pend=%b expected duty=%0d load=1 pend=%b",
                             k, d_of(0), duty_load, pending[0], exp_s[k], (k < 6));
                end
            end
        end
`else
        pulse_pe();
        checks++;
        if (d_of(0) !== 12'd100 || pending[0] !== 1'b0) begin
            errs++; $display("FAIL direct_commit: got duty=%0d pend=%b expected duty=100 pend=0", d_of(0), pending[0]);
        end
`endif
        pulse_pe();
        checks++;
        if ({duty_load, d_of(0)} !== {1'b0, 12'd100}) begin errs++; $display("FAIL settled: got load=%b duty=%0d expected load=0 duty=100", duty_load, d_of(0)); end
    endtask

    initial begin
        test_reset();
`ifndef SLEW_LIMIT_EN
        test_commit();
`endif
        test_arbitration();
`ifndef SLEW_LIMIT_EN
        test_overwrite();
        test_coincident();
`endif
        test_slew();
        checks++;
        if (bad_ch !== 1'b0) begin errs++; $display("FAIL bad_ch_idle: got %b expected 0", bad_ch); end
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
